// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: frames a byte stream (word count, LE words,
// XOR checksum), writes each word into imem and holds the core until the image verifies.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, CHK, DONE, ERR} state_t;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t              state, next_state;
  logic [7:0]          n_lo;
  logic [7:0]          chk;
  logic [ADDR_WIDTH:0] n_words;
  logic [1:0]          byte_idx;

  logic                accept;
  logic [15:0]         n_hdr;
  logic                hdr_ok;
  logic [ADDR_WIDTH:0] count_next;
  logic                enter_hdr0;
  logic                enter_done;
  logic                enter_err;

  assign accept     = byte_valid & byte_ready;
  assign n_hdr      = {byte_data, n_lo};
  assign hdr_ok     = (n_hdr != 16'd0) && (n_hdr <= MAX_N);
  assign count_next = word_count + 1'b1;
  assign enter_hdr0 = (next_state == HDR0) && (state != HDR0);
  assign enter_done = (next_state == DONE) && (state != DONE);
  assign enter_err  = (next_state == ERR)  && (state != ERR);

  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = HDR0;
      HDR0:  if (accept) next_state = HDR1;
      HDR1:  if (accept) next_state = hdr_ok ? DATA : ERR;
      DATA:  if (accept && byte_idx == 2'd3) next_state = WRITE;
      WRITE: next_state = (count_next == n_words) ? CHK : DATA;
      CHK:   if (accept) next_state = (byte_data == chk) ? DONE : ERR;
      DONE,
      ERR:   if (start) next_state = HDR0;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and write strobe are registered decodes of the state being entered,
  // so they are glitch-free and line up exactly with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      n_lo       <= '0;
      n_words    <= '0;
      chk        <= '0;
      byte_idx   <= '0;
    end else begin
      byte_ready <= (next_state == HDR0) || (next_state == HDR1) ||
                    (next_state == DATA) || (next_state == CHK);
      imem_we    <= (next_state == WRITE);

      if (enter_hdr0) begin
        word_count <= '0;
        imem_addr  <= '0;
        chk        <= '0;
        byte_idx   <= '0;
        done       <= 1'b0;
        error      <= 1'b0;
        cpu_hold   <= 1'b1;
      end

      if (state == HDR0 && accept) n_lo <= byte_data;
      if (state == HDR1 && accept) n_words <= n_hdr[ADDR_WIDTH:0];

      if (state == DATA && accept) begin
        imem_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
        chk      <= chk ^ byte_data;
        byte_idx <= byte_idx + 1'b1;
      end

      // The address counter is ADDR_WIDTH wide, so a full-size image wraps it to 0.
      if (state == WRITE) begin
        word_count <= count_next;
        imem_addr  <= imem_addr + 1'b1;
      end

      if (enter_done) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (enter_err) begin
        error    <= 1'b1;
        cpu_hold <= 1'b1;
      end
    end
  end

endmodule
